fifo_consumer: RTL and testbench

- Drains the sync FIFO that `fifo_producer` fills.
- Pops words in arbitrated bursts and writes them into a single-port buffer SRAM over an address range `addr_begin`..`addr_end` that advances by `addr_step`.
- Sits directly downstream of the FIFO and mirrors the producer's request/grant and `soft_rst`/`done` control style.

---
 rtl/fifo_consumer_if.sv | 38 +++
 rtl/fifo_consumer.sv | 128 ++++++++++++
 tb/tb_fifo_consumer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_consumer_if.sv
// fifo_consumer_if: control, arbitration, FIFO-read and SRAM-write signals of fifo_consumer.
interface fifo_consumer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  logic                  soft_rst;
  logic                  done;
  logic                  request;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] addr_begin;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic [ADDR_WIDTH-1:0] addr_end;
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  to_buffer_cs;
  logic                  to_buffer_oe;
  logic [ADDR_WIDTH-1:0] to_buffer_addr;
  logic                  to_buffer_W_req;
  logic [DATA_WIDTH-1:0] to_buffer_W_data;
  logic [DATA_WIDTH-1:0] to_buffer_R_data;

  // consumer side
  modport master (
    input  soft_rst, grant, addr_begin, addr_step, addr_end,
           fifo_empty, fifo_data_out, to_buffer_R_data,
    output done, request, fifo_r_en,
           to_buffer_cs, to_buffer_oe, to_buffer_addr, to_buffer_W_req, to_buffer_W_data
  );

  // environment side: FIFO, arbiter, SRAM and control
  modport slave (
    output soft_rst, grant, addr_begin, addr_step, addr_end,
           fifo_empty, fifo_data_out, to_buffer_R_data,
    input  done, request, fifo_r_en,
           to_buffer_cs, to_buffer_oe, to_buffer_addr, to_buffer_W_req, to_buffer_W_data
  );
endinterface

// File: rtl/fifo_consumer.sv
// fifo_consumer: drains the fifo_producer FIFO into the buffer SRAM in arbitrated bursts,
// writing addr_begin..addr_end in addr_step increments (modulo 2^ADDR_WIDTH).
module fifo_consumer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int BURST_SIZE = 4
) (
  input logic             clk,
  input logic             rst,
  fifo_consumer_if.master bus
);
  // state | meaning
  // IDLE  | after reset, waiting for soft_rst
  // WAIT  | requesting the buffer while the FIFO has data, waiting for grant
  // BURST | popping up to BURST_SIZE words, one per cycle while not empty
  // DRAIN | write of the final pop lands; go to DONE or back to WAIT
  // DONE  | addr_end issued and written, waiting for soft_rst restart

  localparam logic CS_ENB   = 1'b1;
  localparam logic CS_DIS   = 1'b0;
  localparam logic OE_DIS   = 1'b0;
  localparam logic WREQ_ENB = 1'b1;
  localparam logic WREQ_DIS = 1'b0;
  localparam int   CNT_W    = $clog2(BURST_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BURST = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [CNT_W-1:0]      pop_cnt;
  logic                  last_iss;
  logic                  rd_vld;
  logic                  pop;
  logic                  start;
  logic                  burst_go;
  logic                  iss_at_end;
  logic                  pop_last;
  logic                  unused_r_data;

  assign iss_at_end = (iss_addr == bus.addr_end);
  assign start      = bus.soft_rst && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign burst_go   = (state_q == S_WAIT) && bus.grant && !bus.fifo_empty;
  // the pop issued this cycle either fills the burst or issues addr_end
  assign pop_last   = pop && ((pop_cnt == CNT_W'(BURST_SIZE - 1)) || iss_at_end);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; soft_rst only matters in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.soft_rst) state_d = S_WAIT;
      S_WAIT:         if (burst_go)     state_d = S_BURST;
      S_BURST:        if (pop_last)     state_d = S_DRAIN;
      S_DRAIN:        state_d = last_iss ? S_DONE : S_WAIT;
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM outputs: arbitration request, pop strobe and done flag.
  always_comb begin
    bus.request = 1'b0;
    bus.done    = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_WAIT:  bus.request = !bus.fifo_empty;
      S_BURST: begin
        // grant is not re-checked mid-burst; an empty FIFO just stalls the pop
        bus.request = 1'b1;
        pop = !bus.fifo_empty && (pop_cnt < CNT_W'(BURST_SIZE)) && !last_iss;
      end
      S_DRAIN: bus.request = 1'b1;
      S_DONE:  bus.done    = 1'b1;
      default: ;
    endcase
  end

  assign bus.fifo_r_en = pop;

  // Issue/write address tracking, burst counter and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_addr <= '0;
      wr_addr  <= '0;
      pop_cnt  <= '0;
      last_iss <= 1'b0;
      rd_vld   <= 1'b0;
    end else begin
      rd_vld <= pop;
      if (start) begin
        iss_addr <= bus.addr_begin;
        wr_addr  <= bus.addr_begin;
        last_iss <= 1'b0;
      end else begin
        if (rd_vld) wr_addr <= wr_addr + bus.addr_step;
        if (pop) begin
          pop_cnt <= pop_cnt + CNT_W'(1);
          if (iss_at_end) last_iss <= 1'b1;
          else            iss_addr <= iss_addr + bus.addr_step;
        end else if (burst_go) begin
          pop_cnt <= '0;
        end
      end
    end
  end

  // SRAM write port: keyed only off rd_vld so a write in DRAIN always completes.
  always_comb begin
    bus.to_buffer_cs     = rd_vld ? CS_ENB : CS_DIS;
    bus.to_buffer_W_req  = rd_vld ? WREQ_ENB : WREQ_DIS;
    bus.to_buffer_W_data = rd_vld ? bus.fifo_data_out : '0;
  end

  assign bus.to_buffer_addr = wr_addr;
  assign bus.to_buffer_oe   = OE_DIS;
  assign unused_r_data      = ^bus.to_buffer_R_data;
endmodule

// File: tb/tb_fifo_consumer.sv
// tb_fifo_consumer: table-driven scenarios plus randomized runs of fifo_consumer against
// a FIFO model and an address/data scoreboard derived from begin + k*step.
module tb_fifo_consumer;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int BS = 4;
  localparam logic CS_ENB   = 1'b1;
  localparam logic CS_DIS   = 1'b0;
  localparam logic OE_DIS   = 1'b0;
  localparam logic WREQ_ENB = 1'b1;
  localparam logic WREQ_DIS = 1'b0;

  typedef struct {
    logic [AW-1:0] a_begin;
    logic [AW-1:0] a_step;
    int            n;
    logic [DW-1:0] d0;
    int            preload;
    int            refill_delay;
    int            grant_hold;
    int            exp_rises;
    int            exp_first_pop;
    int            exp_done_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_mem [0:4095];
  logic [11:0]   wr_ptr = '0;
  logic [11:0]   rd_ptr = '0;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] exp_q [$];

  fifo_consumer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_consumer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_SIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty       = (wr_ptr == rd_ptr);
  assign bus.fifo_data_out    = fifo_dout;
  assign bus.to_buffer_R_data = '0;

  // Sync FIFO model: data valid the cycle after a pop.
  always @(posedge clk) begin
    if (bus.fifo_r_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 12'd1;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 12'd1;
    exp_q.push_back(d);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_done"},   int'(bus.done), 0);
    check({tag, "_req"},    int'(bus.request), 0);
    check({tag, "_ren"},    int'(bus.fifo_r_en), 0);
    check({tag, "_cs"},     int'(bus.to_buffer_cs), int'(CS_DIS));
    check({tag, "_oe"},     int'(bus.to_buffer_oe), int'(OE_DIS));
    check({tag, "_wreq"},   int'(bus.to_buffer_W_req), int'(WREQ_DIS));
    check({tag, "_wdata"},  int'(bus.to_buffer_W_data), 0);
    check({tag, "_addr"},   int'(bus.to_buffer_addr), 0);
  endtask

  // Starts one transfer from IDLE/DONE and scores every SRAM write against begin + k*step.
  task automatic run_case(input string tag, input vec_t v, input bit rnd);
    int cyc, wr_cnt, rises, first_pop, done_cyc, last_wr, empty_cnt, pushed;
    bit prev_ren;
    logic [AW-1:0] exp_addr;
    cyc = 0; wr_cnt = 0; rises = 0; first_pop = -1; done_cyc = -1;
    last_wr = -1; empty_cnt = 0; prev_ren = 1'b0;
    exp_q.delete();
    for (int i = 0; i < v.preload; i++)
      push_word(rnd ? DW'($urandom) : v.d0 + DW'(i));
    pushed = v.preload;
    bus.addr_begin = v.a_begin;
    bus.addr_step  = v.a_step;
    bus.addr_end   = v.a_begin + AW'(v.n - 1) * v.a_step;
    bus.soft_rst   = 1'b1;
    @(negedge clk);
    bus.soft_rst = 1'b0;
    while (cyc < 400) begin
      bus.grant = rnd ? 1'($urandom_range(0, 1)) : (cyc >= v.grant_hold);
      if (bus.to_buffer_cs == CS_ENB) begin
        check({tag, "_wreq_on"}, int'(bus.to_buffer_W_req), int'(WREQ_ENB));
        if (wr_cnt < v.n) begin
          exp_addr = v.a_begin + AW'(wr_cnt) * v.a_step;
          check({tag, "_wr_addr"}, int'(bus.to_buffer_addr), int'(exp_addr));
          check({tag, "_wr_data"}, int'(bus.to_buffer_W_data), int'(exp_q[wr_cnt]));
        end
        wr_cnt++;
        last_wr = cyc;
      end else begin
        check({tag, "_wreq_off"}, int'(bus.to_buffer_W_req), int'(WREQ_DIS));
        check({tag, "_wdata_off"}, int'(bus.to_buffer_W_data), 0);
      end
      if (bus.fifo_r_en) begin
        check({tag, "_pop_on_empty"}, int'(bus.fifo_empty), 0);
        if (!prev_ren) rises++;
        if (first_pop < 0) first_pop = cyc;
      end
      prev_ren = bus.fifo_r_en;
      if (cyc < v.grant_hold) begin
        check({tag, "_hold_req"}, int'(bus.request), 1);
        check({tag, "_hold_ren"}, int'(bus.fifo_r_en), 0);
      end
      if (!rnd && bus.fifo_empty && (pushed < v.n)) begin
        check({tag, "_stall_req"}, int'(bus.request), 1);
        check({tag, "_stall_ren"}, int'(bus.fifo_r_en), 0);
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (rnd) begin
        if ((pushed < v.n) && ($urandom_range(0, 1) == 1)) begin
          push_word(DW'($urandom));
          pushed++;
        end
      end else if (pushed < v.n) begin
        if (bus.fifo_empty) empty_cnt++;
        if (empty_cnt >= v.refill_delay) begin
          for (int i = pushed; i < v.n; i++) push_word(v.d0 + DW'(i));
          pushed = v.n;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    check({tag, "_wr_count"}, wr_cnt, v.n);
    check({tag, "_done_after_last_wr"}, done_cyc - last_wr, 1);
    if (!rnd) begin
      check({tag, "_bursts"}, rises, v.exp_rises);
      check({tag, "_first_pop"}, first_pop, v.exp_first_pop);
      check({tag, "_done_cyc"}, done_cyc, v.exp_done_cyc);
    end
  endtask

  initial begin
    vec_t tbl [6];
    vec_t r;
    tbl[0] = '{20'h00010, 20'h00001, 8, 16'h00A0, 8, 0, 0, 2, 1, 12}; // two full bursts
    tbl[1] = '{20'h00005, 20'h00001, 1, 16'h00C5, 1, 0, 0, 1, 1, 3};  // single word
    tbl[2] = '{20'h00100, 20'h00001, 6, 16'h00B0, 2, 3, 0, 3, 1, 12}; // empty stall mid-burst
    tbl[3] = '{20'h00200, 20'h00003, 4, 16'h00D0, 4, 0, 5, 1, 6, 11}; // grant withheld 5 cycles
    tbl[4] = '{20'hFFFFE, 20'h00002, 3, 16'h00E0, 3, 0, 0, 1, 1, 5};  // wrap with step 2
    tbl[5] = '{20'h00040, 20'h00001, 2, 16'h00F0, 2, 0, 0, 1, 1, 4};  // restart from DONE

    bus.soft_rst   = 1'b0;
    bus.grant      = 1'b0;
    bus.addr_begin = '0;
    bus.addr_step  = '0;
    bus.addr_end   = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // reset asserted in the middle of a burst
    for (int i = 0; i < 8; i++) push_word(DW'(16'h0300 + i));
    bus.addr_begin = 20'h00300;
    bus.addr_step  = 20'h00001;
    bus.addr_end   = 20'h00307;
    bus.grant      = 1'b1;
    bus.soft_rst   = 1'b1;
    @(negedge clk);
    bus.soft_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_burst_pop", int'(bus.fifo_r_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cs", int'(bus.to_buffer_cs), int'(CS_DIS));
    check("post_rst_req", int'(bus.request), 0);
    wr_ptr = rd_ptr;
    bus.grant = 1'b0;

    for (int k = 0; k < 6; k++) run_case($sformatf("vec%0d", k), tbl[k], 1'b0);

    for (int k = 0; k < 25; k++) begin
      r.n             = $urandom_range(1, 12);
      r.a_begin       = AW'($urandom);
      r.a_step        = AW'($urandom_range(1, 8));
      r.d0            = '0;
      r.preload       = $urandom_range(0, r.n);
      r.refill_delay  = 0;
      r.grant_hold    = 0;
      r.exp_rises     = -1;
      r.exp_first_pop = -1;
      r.exp_done_cyc  = -1;
      run_case($sformatf("rnd%0d", k), r, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
